accumulate_queue_ctrl: RTL
==========================

Name: accumulate_queue_ctrl

Overview:
- Sequencer for one AccumulateQueue instance in the matmul output path.
- Feeds partial sums from the array into the queue for a configured number of passes, then drains the accumulated results over a valid/ready output stream.
- Owns the queue's stall and a_in inputs. The queue's a_out returns to this block.
- Sits between the systolic array output and the writeback buffer.

Parameters:
- A_BITS, 32, width of partial sums and results.
- FIFO_LENGTH, 8, entries in the controlled AccumulateQueue, i.e. tile length; must be >= 2.
- PASS_BITS, 8, width of the pass-count configuration.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cfg_start  in  1  pulse: begin a job when IDLE
- cfg_passes  in  PASS_BITS  number of accumulate passes; sampled on an accepted cfg_start
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last result is accepted
- cfg_error  out  1  one-cycle pulse on cfg_start with cfg_passes==0
- in_valid  in  1  partial sum available
- in_ready  out  1  controller accepts in_data this cycle
- in_data  in  A_BITS  partial sum
- q_stall  out  1  to AccumulateQueue stall; 0 = queue advances this cycle
- q_a_in  out  A_BITS  to AccumulateQueue a_in
- q_a_out  in  A_BITS  from AccumulateQueue a_out
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_data  out  A_BITS  accumulated result

Behaviour:
- Queue contract:
  - The queue advances exactly on cycles with q_stall=0.
  - On an advancing cycle, q_a_out holds the current accumulated value of the slot leaving the queue.
  - The slot re-enters holding that value plus q_a_in.
- Reset values: state=IDLE, q_stall=1, q_a_in=0, in_ready=0, out_valid=0, out_data=0, busy=0, done=0, cfg_error=0, slot_cnt=0, pass_cnt=0.
- Counters: slot_cnt runs 0..FIFO_LENGTH-1 and wraps to 0. pass_cnt is PASS_BITS wide.
- IDLE:
  - q_stall=1.
  - On cfg_start with cfg_passes!=0: latch cfg_passes, clear both counters, go to ACCUM.
  - On cfg_start with cfg_passes==0: pulse cfg_error next cycle and stay in IDLE.
- ACCUM:
  - in_ready=1.
  - q_stall = ~in_valid.
  - q_a_in = in_data when in_valid, else 0.
  - Each accepted beat increments slot_cnt.
  - On the wrap from FIFO_LENGTH-1, increment pass_cnt.
  - When pass_cnt reaches the latched passes on that wrap, go to DRAIN (in_ready=0 from the next cycle).
- DRAIN:
  - in_ready=0. q_a_in=0.
  - Advance condition: adv = ~out_valid | out_ready. q_stall = ~adv.
  - On adv: out_data <= q_a_out, out_valid <= 1, slot_cnt increments.
  - Each queue advance recirculates the slot with a_in=0; the bench clears the queue with a reset between jobs if required.
  - After FIFO_LENGTH advances, go to FLUSH.
- FLUSH:
  - q_stall=1.
  - Hold until the final out_valid beat is accepted, then pulse done and go to IDLE.
- Output handshake:
  - out_valid is held until out_ready; out_data is stable while out_valid && !out_ready.
  - Latency: one cycle from queue advance to out_valid.
- cfg_start is ignored in every state except IDLE.
- reset asserted mid-job: all state returns to reset values on the next edge. Pending out_valid is dropped and no done pulse is issued.
- Width: no arithmetic in the controller beyond the counters. Accumulation overflow is the queue's behaviour (modulo 2^A_BITS).
- The output path sustains 1 result/cycle when out_ready is held high.

Optional Feature:
- Macro: ACCQ_CTRL_PERF_EN.
- Defined:
  - Adds outputs perf_in_stall (32 bit): ACCUM cycles with in_valid=0.
  - Adds outputs perf_out_stall (32 bit): cycles with out_valid && !out_ready.
  - Both cleared on reset and on an accepted cfg_start, saturating at all-ones.
- Undefined: both ports and counters are absent. Functional behaviour is identical.

Test Plan:
- Basic job, FIFO_LENGTH=8, passes=2, queue freshly reset, out_ready=1:
  - Stimulus: in_data 0..7 then 10..17, in_valid=1 continuously.
  - Response: outputs 10,12,14,16,18,20,22,24 in order, one per cycle; done pulses once; busy returns to 0.
- Input bubbles, passes=1:
  - Stimulus: in_valid toggles 1,0 per cycle, data 1..8.
  - Response: q_stall=1 exactly on the bubble cycles; outputs 1..8; perf_in_stall=7 with ACCQ_CTRL_PERF_EN.
- Output backpressure, passes=1, data 5 x8:
  - Stimulus: out_ready low for 3 cycles after the first out_valid.
  - Response: out_data holds 5, queue does not advance (q_stall=1), eight 5s total, no loss or duplicate.
- Config error and ignore:
  - Stimulus: cfg_start with cfg_passes=0; then cfg_start while busy.
  - Response: cfg_error pulses once, state stays IDLE; the mid-job start has no effect on the result stream.
- Reset mid-DRAIN, passes=1:
  - Stimulus: assert reset after 3 results.
  - Response: next cycle out_valid=0, busy=0, q_stall=1, no done pulse; a new job after reset completes correctly.

Source files
------------

// File: rtl/accumulate_queue_ctrl.sv
// accumulate_queue_ctrl: sequencer for one AccumulateQueue in the matmul output path.
// It accumulates partial sums from the array into the queue for a configured number of
// passes, then drains the accumulated results over a valid/ready stream.
// Optional build macro: ACCQ_CTRL_PERF_EN adds two saturating 32-bit stall counters
// (perf_in_stall, perf_out_stall). With the macro undefined they are absent.
module accumulate_queue_ctrl #(
    parameter int A_BITS      = 32,
    parameter int FIFO_LENGTH = 8,
    parameter int PASS_BITS   = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cfg_start,
    input  logic [PASS_BITS-1:0] cfg_passes,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_error,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_BITS-1:0]    in_data,
    output logic                 q_stall,
    output logic [A_BITS-1:0]    q_a_in,
    input  logic [A_BITS-1:0]    q_a_out,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef ACCQ_CTRL_PERF_EN
    output logic [31:0]          perf_in_stall,
    output logic [31:0]          perf_out_stall,
`endif
    output logic [A_BITS-1:0]    out_data
);

    localparam int SLOT_W = (FIFO_LENGTH > 1) ? $clog2(FIFO_LENGTH) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(FIFO_LENGTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [SLOT_W-1:0]    slot_cnt;
    logic [PASS_BITS-1:0] pass_cnt;
    logic [PASS_BITS-1:0] passes_lat;
    logic [PASS_BITS-1:0] pass_inc;

    logic start_ok;
    logic start_bad;
    logic adv;
    logic accum_beat;
    logic drain_adv;
    logic slot_last;
    logic last_pass;
    logic flush_exit;

    // A start is only honoured in IDLE; a zero pass count is rejected there.
    assign start_ok   = (state == S_IDLE) && cfg_start && (|cfg_passes);
    assign start_bad  = (state == S_IDLE) && cfg_start && ~(|cfg_passes);
    // Output register can take a new result when empty or being emptied this cycle.
    assign adv        = ~out_valid | out_ready;
    assign accum_beat = (state == S_ACCUM) && in_valid;
    assign drain_adv  = (state == S_DRAIN) && adv;
    assign slot_last  = (slot_cnt == SLOT_LAST);
    assign pass_inc   = pass_cnt + PASS_BITS'(1);
    assign last_pass  = (pass_inc == passes_lat);
    // In FLUSH the last result sits in the output register; leave once it is taken.
    assign flush_exit = (state == S_FLUSH) && adv;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_ok) state_nxt = S_ACCUM;
            S_ACCUM: if (accum_beat && slot_last && last_pass) state_nxt = S_DRAIN;
            S_DRAIN: if (drain_adv && slot_last) state_nxt = S_FLUSH;
            S_FLUSH: if (flush_exit) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Per-state queue and input-side controls.
    always_comb begin
        busy     = 1'b1;
        in_ready = 1'b0;
        q_stall  = 1'b1;
        q_a_in   = '0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_ACCUM: begin
                in_ready = 1'b1;
                q_stall  = ~in_valid;
                q_a_in   = in_valid ? in_data : '0;
            end
            S_DRAIN: begin
                q_stall = ~adv;
            end
            default: begin
                q_stall = 1'b1;
            end
        endcase
    end

    // Slot and pass counters; the slot counter tracks queue position in both phases.
    always_ff @(posedge clock) begin
        if (reset) begin
            slot_cnt   <= '0;
            pass_cnt   <= '0;
            passes_lat <= '0;
        end else if (start_ok) begin
            slot_cnt   <= '0;
            pass_cnt   <= '0;
            passes_lat <= cfg_passes;
        end else if (accum_beat || drain_adv) begin
            slot_cnt <= slot_last ? '0 : slot_cnt + SLOT_W'(1);
            if (accum_beat && slot_last) begin
                pass_cnt <= pass_inc;
            end
        end
    end

    // Result register and status pulses; one cycle from queue advance to out_valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
            cfg_error <= 1'b0;
        end else begin
            done      <= flush_exit;
            cfg_error <= start_bad;
            if (drain_adv) begin
                out_valid <= 1'b1;
                out_data  <= q_a_out;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef ACCQ_CTRL_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    // Stall counters, cleared on reset and on each accepted job start.
    always_ff @(posedge clock) begin
        if (reset || start_ok) begin
            perf_in_stall  <= '0;
            perf_out_stall <= '0;
        end else begin
            if ((state == S_ACCUM) && !in_valid) begin
                perf_in_stall <= sat_inc(perf_in_stall);
            end
            if (out_valid && !out_ready) begin
                perf_out_stall <= sat_inc(perf_out_stall);
            end
        end
    end
`endif

endmodule
